// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light controller: ST restarts, TS/TL flag timeouts.
// Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module traffic_timer #(
   parameter int SHORT_CNT = 5,
   parameter int LONG_CNT  = 15,
   parameter int CW        = 8,
   parameter int PRESCALE  = 10
) (
   input  logic          Clk,
   input  logic          reset,
   input  logic          ST,
   output logic          TS,
   output logic          TL,
   output logic          BUSY,
   output logic [CW-1:0] CNT
);

   if (SHORT_CNT < 1 || SHORT_CNT >= LONG_CNT ||
       LONG_CNT > (2 ** CW) - 1 || PRESCALE < 2) begin : g_bad_params
      $error("traffic_timer: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt_n;
   logic [CW-1:0] cnt_inc;
   logic          ts_n;
   logic          tl_n;
   logic          busy_n;
   logic          tick;

`ifdef TIMER_PRESCALE_EN
   localparam int PW = $clog2(PRESCALE);

   logic [PW-1:0] pre, pre_n;

   assign tick = (pre == PW'(PRESCALE - 1));

   // Prescaler only runs while counting; ST realigns it to a fresh tick.
   always_comb begin
      pre_n = pre;
      if (ST)
         pre_n = '0;
      else if (state == RUN)
         pre_n = tick ? '0 : pre + PW'(1);
   end

   always_ff @(posedge Clk) begin
      if (reset)
         pre <= '0;
      else
         pre <= pre_n;
   end
`else
   assign tick = 1'b1;
`endif

   assign cnt_inc = CNT + CW'(1);

   always_comb begin
      state_n = state;
      cnt_n   = CNT;
      ts_n    = TS;
      tl_n    = TL;
      busy_n  = BUSY;
      if (ST) begin
         state_n = RUN;
         cnt_n   = '0;
         ts_n    = 1'b0;
         tl_n    = 1'b0;
         busy_n  = 1'b1;
      end else begin
         unique case (state)
            IDLE: ;
            RUN: begin
               if (tick) begin
                  cnt_n = cnt_inc;
                  ts_n  = (cnt_inc >= CW'(SHORT_CNT));
                  // Saturate at LONG_CNT: the counter never wraps.
                  if (cnt_inc >= CW'(LONG_CNT)) begin
                     tl_n    = 1'b1;
                     busy_n  = 1'b0;
                     state_n = EXPIRED;
                  end
               end
            end
            EXPIRED: ;
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               ts_n    = 1'b0;
               tl_n    = 1'b0;
               busy_n  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state <= IDLE;
         CNT   <= '0;
         TS    <= 1'b0;
         TL    <= 1'b0;
         BUSY  <= 1'b0;
      end else begin
         state <= state_n;
         CNT   <= cnt_n;
         TS    <= ts_n;
         TL    <= tl_n;
         BUSY  <= busy_n;
      end
   end

endmodule
